pong_score: RTL and testbench
=============================

# pong_score

Scoring and serve controller that sits directly downstream of the ball stage. It watches the ball's vertical position for the teleport-to-centre that marks a missed ball, and credits the point to the correct player. It holds the ball in reset during a serve pause and declares a winner. Its `ball_reset` output is OR-ed with the system reset to drive the ball stage's reset input.

## Interface
Parameters:
- `START_Y`, 9'd160: ball re-spawn row; a goal is only recognised when `ball_y` equals this.
- `HI_EDGE`, 9'd300: previous `ball_y` at or above this, followed by `START_Y`, means the ball passed player 2. Player 1 scores.
- `LO_EDGE`, 9'd20: previous `ball_y` at or below this, followed by `START_Y`, means the ball passed player 1. Player 2 scores.
- `WIN_SCORE`, 4'd9: score that ends the game.
- `PAUSE_CYCLES`, 8'd120: serve pause length in clock cycles; legal range 1–255.

Ports:
- `clock` in 1: game clock, the same clock as the ball stage.
- `reset` in 1: reset, synchronous, active-high.
- `ball_y` in 9: ball vertical position from the ball stage.
- `start` in 1: restart button level, already synchronised.
- `score_1` out 4: player 1 score, binary 0..WIN_SCORE.
- `score_2` out 4: player 2 score.
- `goal_pulse` out 1: one-cycle pulse when a point is credited.
- `scorer` out 1: player credited by the most recent goal; 0 = player 1, 1 = player 2.
- `ball_reset` out 1: holds the ball stage in reset.
- `game_over` out 1: high while in OVER.
- `winner` out 1: valid when `game_over` is high; 0 = player 1.

## Operation
- Every cycle, `prev_y <= ball_y`. On reset, `prev_y = START_Y`.
- Goal conditions (combinational):
  - `g1 = (ball_y == START_Y) && (prev_y >= HI_EDGE)`
  - `g2 = (ball_y == START_Y) && (prev_y <= LO_EDGE)`
  - g1 and g2 are mutually exclusive given the default edges.
- FSM states: PLAY, SERVE, OVER. Reset enters PLAY.
- PLAY:
  - On g1 or g2: increment the scorer's count, pulse `goal_pulse`, and set `scorer`.
  - If the new count equals WIN_SCORE: go to OVER and set `winner = scorer`.
  - Otherwise: go to SERVE and load `pause_cnt = PAUSE_CYCLES-1`.
  - No goal: stay in PLAY.
- SERVE: goal conditions are ignored. `pause_cnt` decrements each cycle; when it is 0, go to PLAY.
- OVER: scores are frozen and goals are ignored. A rising edge on `start` (registered `start_d`) clears both scores and goes to SERVE with the pause loaded.
- `ball_reset = 1` in SERVE and OVER, 0 in PLAY; it is a registered decode of state.
- `start` held high across reset does not count as a rising edge; `start_d` resets to 1.
- Scores never exceed WIN_SCORE; no wrap is possible.
- Reset mid-SERVE or mid-OVER: return immediately to PLAY with scores 0. The ball stage is reset simultaneously by the system reset.

## Timing
- Reset values: `score_1 = 0`, `score_2 = 0`, `goal_pulse = 0`, `scorer = 0`, `ball_reset = 0`, `game_over = 0`, `winner = 0`, `pause_cnt = 0`.
- Goal latency: `ball_y` shows START_Y in cycle N. Then in cycle N+1, the score, `goal_pulse`, `scorer` and `ball_reset`/`game_over` are all visible together.
- `ball_reset` stays high for exactly PAUSE_CYCLES cycles (N+1 .. N+PAUSE_CYCLES). It is low again at N+PAUSE_CYCLES+1.
- Restart from OVER: rising edge of `start` sampled at cycle M. Scores read 0 at M+1; `ball_reset` remains high through M+PAUSE_CYCLES.
- A goal arriving in the first PLAY cycle after SERVE is accepted. `prev_y` is START_Y then, so a false goal is impossible.

## Structure
- Shared package `pong_pkg`:
  - state enum {PLAY, SERVE, OVER}
  - player encoding constants `P1 = 1'b0`, `P2 = 1'b1`
  - screen constants START_Y, HI_EDGE and LO_EDGE, shared with the ball stage
- One sub-module, `score_counter`: a 4-bit counter with `clear`, `inc`, and a `hit_win` compare against WIN_SCORE. It is instantiated twice, once per player.
- FSM, pause counter and goal detection live in the top level.

## Test plan
- Drive `ball_y` 305 then 160 → next cycle `score_1 = 1`, `goal_pulse = 1`, `scorer = 0`; `ball_reset` high for 120 cycles, then low.
- Drive `ball_y` 10 then 160 → `score_2 = 1`, `scorer = 1`. Repeat the goal during SERVE → no score change.
- Drive `ball_y` 200 then 160 (centre pass, no edge) → no goal and no pulse.
- Eight goals for player 2, then a ninth → `score_2 = 9`, `game_over = 1`, `winner = 1`, `ball_reset` stays high. Further goals are ignored.
- In OVER, hold `start` high and then pulse it → scores clear to 0 one cycle after the rising edge; `game_over` drops; `ball_reset` is held for 120 cycles.
- Assert reset mid-SERVE at pause count 50 → next cycle PLAY, all outputs at reset values, and `prev_y = 160`.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: game states, player encoding and screen rows
// common to the ball stage and the scoring controller.
package pong_pkg;

    typedef enum logic [1:0] {
        PLAY,
        SERVE,
        OVER
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [8:0] START_Y = 9'd160;
    localparam logic [8:0] HI_EDGE = 9'd300;
    localparam logic [8:0] LO_EDGE = 9'd20;

endpackage

// File: rtl/pong_score_counter.sv
// Per-player point counter; hit_win flags that the pending increment
// would bring the count to the winning score.
module score_counter #(
    parameter logic [3:0] WIN_SCORE = 4'd9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] count,
    output logic       hit_win
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 4'd1;
        end
    end

    assign hit_win = ((count + 4'd1) == WIN_SCORE);

endmodule

// File: rtl/pong_score.sv
// Scoring and serve controller: detects the ball re-spawn after a miss,
// credits the point, holds the ball during the serve pause, declares a winner.
module pong_score
    import pong_pkg::*;
#(
    parameter logic [8:0] START_Y      = pong_pkg::START_Y,
    parameter logic [8:0] HI_EDGE      = pong_pkg::HI_EDGE,
    parameter logic [8:0] LO_EDGE      = pong_pkg::LO_EDGE,
    parameter logic [3:0] WIN_SCORE    = 4'd9,
    parameter logic [7:0] PAUSE_CYCLES = 8'd120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] ball_y,
    input  logic       start,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       goal_pulse,
    output logic       scorer,
    output logic       ball_reset,
    output logic       game_over,
    output logic       winner
);

    state_t     state;
    state_t     state_next;
    logic [7:0] pause_cnt;
    logic [7:0] pause_next;
    logic [8:0] prev_y;
    logic       start_d;

    logic g1;
    logic g2;
    logic goal;
    logic win;
    logic who;
    logic clear;
    logic inc_1;
    logic inc_2;
    logic hit_1;
    logic hit_2;

    assign g1 = (ball_y == START_Y) && (prev_y >= HI_EDGE);
    assign g2 = (ball_y == START_Y) && (prev_y <= LO_EDGE);

    score_counter #(.WIN_SCORE(WIN_SCORE)) u_score_1 (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .inc     (inc_1),
        .count   (score_1),
        .hit_win (hit_1)
    );

    score_counter #(.WIN_SCORE(WIN_SCORE)) u_score_2 (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .inc     (inc_2),
        .count   (score_2),
        .hit_win (hit_2)
    );

    always_comb begin
        state_next = state;
        pause_next = pause_cnt;
        goal       = 1'b0;
        win        = 1'b0;
        who        = scorer;
        clear      = 1'b0;
        inc_1      = 1'b0;
        inc_2      = 1'b0;
        case (state)
            PLAY: begin
                if (g1 || g2) begin
                    goal  = 1'b1;
                    who   = g1 ? P1 : P2;
                    inc_1 = g1;
                    inc_2 = !g1;
                    win   = g1 ? hit_1 : hit_2;
                    if (win) begin
                        state_next = OVER;
                    end else begin
                        state_next = SERVE;
                        pause_next = PAUSE_CYCLES - 8'd1;
                    end
                end
            end
            SERVE: begin
                if (pause_cnt == '0) begin
                    state_next = PLAY;
                end else begin
                    pause_next = pause_cnt - 8'd1;
                end
            end
            OVER: begin
                if (start && !start_d) begin
                    clear      = 1'b1;
                    state_next = SERVE;
                    pause_next = PAUSE_CYCLES - 8'd1;
                end
            end
            default: begin
                state_next = PLAY;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the score update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= PLAY;
            pause_cnt  <= '0;
            prev_y     <= START_Y;
            start_d    <= 1'b1;
            goal_pulse <= 1'b0;
            scorer     <= P1;
            winner     <= P1;
            ball_reset <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_next;
            pause_cnt  <= pause_next;
            prev_y     <= ball_y;
            start_d    <= start;
            goal_pulse <= goal;
            if (goal) begin
                scorer <= who;
            end
            if (win) begin
                winner <= who;
            end
            ball_reset <= (state_next != PLAY);
            game_over  <= (state_next == OVER);
        end
    end

endmodule

// File: tb/tb_pong_score.sv
// Directed bench for pong_score: goals, serve pause, game over, restart and reset.
module tb_pong_score;

    logic       clock;
    logic       reset;
    logic [8:0] ball_y;
    logic       start;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       goal_pulse;
    logic       scorer;
    logic       ball_reset;
    logic       game_over;
    logic       winner;

    int n_checks;
    int n_fail;

    pong_score #(
        .START_Y      (9'd160),
        .HI_EDGE      (9'd300),
        .LO_EDGE      (9'd20),
        .WIN_SCORE    (4'd9),
        .PAUSE_CYCLES (8'd120)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ball_y     (ball_y),
        .start      (start),
        .score_1    (score_1),
        .score_2    (score_2),
        .goal_pulse (goal_pulse),
        .scorer     (scorer),
        .ball_reset (ball_reset),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Ends one cycle after ball_y shows 160, i.e. when the goal becomes visible.
    task automatic goal_p1;
        ball_y = 9'd305;
        step;
        ball_y = 9'd160;
        step;
    endtask

    task automatic goal_p2;
        ball_y = 9'd10;
        step;
        ball_y = 9'd160;
        step;
    endtask

    task automatic apply_reset;
        reset  = 1'b1;
        ball_y = 9'd160;
        step;
        step;
        reset  = 1'b0;
    endtask

    task automatic wait_play;
        for (int i = 0; i < 300; i++) begin
            if (ball_reset === 1'b0) break;
            step;
        end
        n_checks++;
        if (ball_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_play: ball_reset=%b required 0 within 300 cycles", ball_reset);
        end
    endtask

    task automatic test_reset;
        start = 1'b0;
        apply_reset;
        n_checks++;
        if ({score_1, score_2} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_scores: got %0d/%0d required 0/0", score_1, score_2);
        end
        n_checks++;
        if ({goal_pulse, scorer, ball_reset, game_over, winner} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got pulse=%b scorer=%b ball_reset=%b over=%b winner=%b required all 0",
                     goal_pulse, scorer, ball_reset, game_over, winner);
        end
    endtask

    task automatic test_goal_p1;
        int hi;
        goal_p1;
        n_checks++;
        if (score_1 !== 4'd1 || score_2 !== 4'd0) begin
            n_fail++;
            $display("FAIL p1_score: got %0d/%0d required 1/0", score_1, score_2);
        end
        n_checks++;
        if (goal_pulse !== 1'b1 || scorer !== 1'b0 || ball_reset !== 1'b1 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_flags: got pulse=%b scorer=%b ball_reset=%b over=%b required 1 0 1 0",
                     goal_pulse, scorer, ball_reset, game_over);
        end
        hi = 1;
        step;
        n_checks++;
        if (goal_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_pulse_width: goal_pulse=%b required 0 on second cycle", goal_pulse);
        end
        if (ball_reset === 1'b1) hi++;
        for (int i = 0; i < 128; i++) begin
            step;
            if (ball_reset === 1'b1) hi++;
        end
        n_checks++;
        if (hi != 120 || ball_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_pause_len: ball_reset high %0d cycles, final %b; required 120, final 0", hi, ball_reset);
        end
    endtask

    task automatic test_goal_p2_and_serve;
        goal_p2;
        n_checks++;
        if (score_2 !== 4'd1 || scorer !== 1'b1 || goal_pulse !== 1'b1 || score_1 !== 4'd1) begin
            n_fail++;
            $display("FAIL p2_goal: got s1=%0d s2=%0d scorer=%b pulse=%b required 1 1 1 1",
                     score_1, score_2, scorer, goal_pulse);
        end
        step;
        goal_p2;
        n_checks++;
        if (score_2 !== 4'd1 || goal_pulse !== 1'b0 || ball_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_ignore: got s2=%0d pulse=%b ball_reset=%b required 1 0 1",
                     score_2, goal_pulse, ball_reset);
        end
        wait_play;
    endtask

    task automatic test_centre_pass;
        ball_y = 9'd200;
        step;
        ball_y = 9'd160;
        step;
        n_checks++;
        if (goal_pulse !== 1'b0 || score_1 !== 4'd1 || score_2 !== 4'd1 || ball_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL centre_pass: got pulse=%b s1=%0d s2=%0d ball_reset=%b required 0 1 1 0",
                     goal_pulse, score_1, score_2, ball_reset);
        end
    endtask

    task automatic test_game_over;
        apply_reset;
        for (int g = 0; g < 8; g++) begin
            goal_p2;
            wait_play;
        end
        n_checks++;
        if (score_2 !== 4'd8 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL eight_goals: got s2=%0d over=%b required 8 0", score_2, game_over);
        end
        start = 1'b1;
        goal_p2;
        n_checks++;
        if (score_2 !== 4'd9 || game_over !== 1'b1 || winner !== 1'b1 || ball_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL ninth_goal: got s2=%0d over=%b winner=%b ball_reset=%b required 9 1 1 1",
                     score_2, game_over, winner, ball_reset);
        end
        n_checks++;
        if (goal_pulse !== 1'b1 || scorer !== 1'b1) begin
            n_fail++;
            $display("FAIL ninth_pulse: got pulse=%b scorer=%b required 1 1", goal_pulse, scorer);
        end
        step;
        goal_p1;
        n_checks++;
        if (score_1 !== 4'd0 || score_2 !== 4'd9 || goal_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL over_frozen: got s1=%0d s2=%0d pulse=%b required 0 9 0", score_1, score_2, goal_pulse);
        end
        for (int i = 0; i < 130; i++) step;
        n_checks++;
        if (game_over !== 1'b1 || ball_reset !== 1'b1 || score_2 !== 4'd9) begin
            n_fail++;
            $display("FAIL start_held: got over=%b ball_reset=%b s2=%0d required 1 1 9",
                     game_over, ball_reset, score_2);
        end
    endtask

    task automatic test_restart;
        int hi;
        start = 1'b0;
        step;
        start = 1'b1;
        step;
        n_checks++;
        if (score_1 !== 4'd0 || score_2 !== 4'd0 || game_over !== 1'b0 || ball_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got s1=%0d s2=%0d over=%b ball_reset=%b required 0 0 0 1",
                     score_1, score_2, game_over, ball_reset);
        end
        hi = 1;
        for (int i = 0; i < 129; i++) begin
            step;
            if (ball_reset === 1'b1) hi++;
        end
        n_checks++;
        if (hi != 120 || ball_reset !== 1'b0 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_pause: ball_reset high %0d cycles, final %b, over=%b; required 120, 0, 0",
                     hi, ball_reset, game_over);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_serve;
        goal_p1;
        for (int i = 0; i < 69; i++) step;
        ball_y = 9'd305;
        reset  = 1'b1;
        step;
        n_checks++;
        if ({score_1, score_2} !== 8'h00 ||
            {goal_pulse, scorer, ball_reset, game_over, winner} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_serve_reset: got s1=%0d s2=%0d pulse=%b scorer=%b ball_reset=%b over=%b winner=%b required all 0",
                     score_1, score_2, goal_pulse, scorer, ball_reset, game_over, winner);
        end
        reset  = 1'b0;
        ball_y = 9'd160;
        step;
        n_checks++;
        if (goal_pulse !== 1'b0 || score_1 !== 4'd0 || ball_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL prev_y_reset: got pulse=%b s1=%0d ball_reset=%b required 0 0 0",
                     goal_pulse, score_1, ball_reset);
        end
        goal_p2;
        n_checks++;
        if (score_2 !== 4'd1 || goal_pulse !== 1'b1 || scorer !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_goal: got s2=%0d pulse=%b scorer=%b required 1 1 1",
                     score_2, goal_pulse, scorer);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        ball_y   = 9'd160;
        test_reset;
        test_goal_p1;
        test_goal_p2_and_serve;
        test_centre_pass;
        test_game_over;
        test_restart;
        test_reset_mid_serve;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
